// File: rtl/core_run_ctrl_if.sv
// Host command channel for the core run controller.
// The host drives op/arg with valid; the controller answers with ready.
interface core_run_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run/step/halt/reset sequencer for the single-cycle core: reset hold,
// clock-enable gating, PC breakpoints and a saturating executed-cycle counter.
module core_run_ctrl #(
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 16,
  parameter int PC_W     = 32,
  parameter int NUM_BP   = 2
) (
  input  logic                   clock,
  input  logic                   rst,
  core_run_ctrl_if.slave         cmd,
  input  logic [PC_W-1:0]        core_pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  output logic                   core_rst,
  output logic                   core_en,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [CNT_W-1:0]       cycle_count
);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  localparam logic [1:0] OP_RUN      = 2'd0;
  localparam logic [1:0] OP_STEP     = 2'd1;
  localparam logic [1:0] OP_HALT     = 2'd2;
  localparam logic [1:0] OP_SOFT_RST = 2'd3;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  typedef enum logic [1:0] {S_RESET, S_HALTED, S_RUN, S_STEP} state_t;

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CNT_W-1:0]  steps_left_reg, steps_left_next;
  logic              resume_reg, resume_next;
  logic [1:0]        halt_cause_reg, halt_cause_next;
  logic [CNT_W-1:0]  cycle_count_reg, cycle_count_next;
  logic              core_rst_reg, halted_reg;
  logic              clear_count;
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit, cmd_fire;

  generate
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_match[gi] = bp_en[gi] && (core_pc == bp_addr[gi*PC_W +: PC_W]);
    end
  endgenerate

  // The breakpoint at the resume PC is masked for exactly one cycle.
  assign bp_hit        = (|bp_match) && !resume_reg;
  assign cmd.cmd_ready = (state_reg != S_RESET);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    steps_left_next = steps_left_reg;
    resume_next     = resume_reg;
    halt_cause_next = halt_cause_reg;
    clear_count     = 1'b0;
    core_en         = 1'b0;
    case (state_reg)
      S_RESET: begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = '0;
          state_next    = S_HALTED;
        end
      end
      S_HALTED: begin
        if (cmd_fire) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              state_next  = S_RUN;
              resume_next = 1'b1;
            end
            OP_STEP: begin
              if (cmd.cmd_arg != '0) begin
                state_next      = S_STEP;
                steps_left_next = cmd.cmd_arg;
                resume_next     = 1'b1;
              end
            end
            OP_SOFT_RST: begin
              state_next      = S_RESET;
              hold_cnt_next   = '0;
              halt_cause_next = CAUSE_NONE;
              clear_count     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        resume_next = 1'b0;
        if (cmd_fire && cmd.cmd_op == OP_SOFT_RST) begin
          state_next      = S_RESET;
          hold_cnt_next   = '0;
          halt_cause_next = CAUSE_NONE;
          clear_count     = 1'b1;
        end else if (bp_hit) begin
          state_next      = S_HALTED;
          halt_cause_next = CAUSE_BP;
        end else if (cmd_fire && cmd.cmd_op == OP_HALT) begin
          state_next      = S_HALTED;
          halt_cause_next = CAUSE_HOST;
        end else begin
          core_en = 1'b1;
          if (state_reg == S_STEP) begin
            steps_left_next = steps_left_reg - CNT_W'(1);
            if (steps_left_reg == CNT_W'(1)) begin
              state_next      = S_HALTED;
              halt_cause_next = CAUSE_STEP;
            end
          end
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    cycle_count_next = cycle_count_reg;
    if (clear_count) begin
      cycle_count_next = '0;
    end else if (core_en && cycle_count_reg != CNT_MAX) begin
      cycle_count_next = cycle_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg       <= S_RESET;
      hold_cnt_reg    <= '0;
      steps_left_reg  <= '0;
      resume_reg      <= 1'b0;
      halt_cause_reg  <= CAUSE_NONE;
      cycle_count_reg <= '0;
      core_rst_reg    <= 1'b1;
      halted_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      steps_left_reg  <= steps_left_next;
      resume_reg      <= resume_next;
      halt_cause_reg  <= halt_cause_next;
      cycle_count_reg <= cycle_count_next;
      core_rst_reg    <= (state_next == S_RESET);
      halted_reg      <= (state_next == S_HALTED);
    end
  end

  assign core_rst    = core_rst_reg;
  assign halted      = halted_reg;
  assign halt_cause  = halt_cause_reg;
  assign cycle_count = cycle_count_reg;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: stimulus queues expected events, a
// negedge monitor detects reset entry, core_rst release and halt entry.
module tb_core_run_ctrl;
  localparam int RST_HOLD = 4;
  localparam int CNT_W    = 4;
  localparam int PC_W     = 32;
  localparam int NUM_BP   = 2;

  localparam int K_RSTV = 0;
  localparam int K_HOLD = 1;
  localparam int K_HALT = 2;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_HALT = 2'd2;
  localparam logic [1:0] OP_SOFT = 2'd3;

  // {core_rst, core_en, halted, cmd_ready, halt_cause, cycle_count} in reset
  localparam logic [31:0] RESET_VEC = 32'h200;

  typedef struct {
    int    kind;
    string name;
    int    v0;
    int    v1;
    int    v2;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   rst   = 1'b0;
  logic [PC_W-1:0]        core_pc;
  logic [NUM_BP-1:0]      bp_en;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic                   core_rst, core_en, halted;
  logic [1:0]             halt_cause;
  logic [CNT_W-1:0]       cycle_count;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  core_run_ctrl_if #(.CNT_W(CNT_W)) cmd ();

  core_run_ctrl #(
    .RST_HOLD(RST_HOLD),
    .CNT_W   (CNT_W),
    .PC_W    (PC_W),
    .NUM_BP  (NUM_BP)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .cmd        (cmd),
    .core_pc    (core_pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Stand-in core: PC advances by 4 inside a 32-byte loop when enabled.
  always @(posedge clock) begin
    if (core_rst === 1'b1) core_pc <= '0;
    else if (core_en === 1'b1) core_pc <= (core_pc + 32'd4) & 32'h1F;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic score(input int kind, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected no event", kind, a0);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got event kind %0d, expected kind %0d", e.name, kind, e.kind);
      return;
    end
    case (kind)
      K_RSTV: check({e.name, " reset outputs"}, a0, e.v0);
      K_HOLD: check({e.name, " core_rst cycles"}, a0, e.v0);
      default: begin
        check({e.name, " halt_cause"}, a0, e.v0);
        check({e.name, " cycle_count"}, a1, e.v1);
        check({e.name, " enabled cycles"}, a2, e.v2);
      end
    endcase
    $display("[%0t] %s kind=%0d a0=%0d a1=%0d a2=%0d", $time, e.name, kind, a0, a1, a2);
  endtask

  initial begin : monitor
    logic rst_q1, rst_q2, core_rst_d, halted_d;
    int   rst_len, en_seg;
    rst_q1 = 1'b0; rst_q2 = 1'b0; core_rst_d = 1'b0; halted_d = 1'b0;
    rst_len = 0; en_seg = 0;
    forever begin
      @(negedge clock);
      if (rst_q1 && !rst_q2)
        score(K_RSTV, {22'd0, core_rst, core_en, halted, cmd.cmd_ready, halt_cause, cycle_count},
              32'd0, 32'd0);
      if (core_rst_d === 1'b1 && core_rst === 1'b0)
        score(K_HOLD, rst_len, 32'd0, 32'd0);
      if (halted === 1'b1 && halted_d !== 1'b1) begin
        score(K_HALT, {30'd0, halt_cause}, {28'd0, cycle_count}, en_seg);
        en_seg = 0;
      end
      if (rst === 1'b1 || core_rst !== 1'b1) rst_len = 0;
      else rst_len++;
      if (rst_q1) en_seg = 0;
      else if (core_en === 1'b1) en_seg++;
      rst_q2     = rst_q1;
      rst_q1     = rst;
      core_rst_d = core_rst;
      halted_d   = halted;
    end
  end

  task automatic push(input int kind, input string name, input int v0, input int v1, input int v2);
    exp_t e;
    e.kind = kind; e.name = name; e.v0 = v0; e.v1 = v1; e.v2 = v2;
    q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_arg   = arg;
    @(posedge clock); #1;
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clock);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: got no event within 300 cycles, expected kind %0d", e.name, e.kind);
    end
    #1;
  endtask

  task automatic soft_reset(input string name);
    push(K_HOLD, name, RST_HOLD, 0, 0);
    push(K_HALT, name, 0, 0, 0);
    issue(OP_SOFT, '0);
    drain();
  endtask

  initial begin : stimulus
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_RUN;
    cmd.cmd_arg   = '0;
    bp_en         = '0;
    bp_addr       = '0;
    @(posedge clock); #1;

    push(K_RSTV, "por", RESET_VEC, 0, 0);
    push(K_HOLD, "por", RST_HOLD, 0, 0);
    push(K_HALT, "por", 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    drain();

    push(K_HALT, "step5", 3, 5, 5);
    issue(OP_STEP, 4'd5);
    drain();

    soft_reset("soft_a");
    bp_en   = 2'b01;
    bp_addr = {32'h40, 32'h10};
    push(K_HALT, "bp_first", 2, 4, 4);
    issue(OP_RUN, '0);
    drain();
    push(K_HALT, "bp_rerun", 2, 12, 8);
    issue(OP_RUN, '0);
    drain();

    bp_en = '0;
    soft_reset("soft_b");
    push(K_HALT, "step10_host", 1, 3, 3);
    issue(OP_STEP, 4'd10);
    repeat (3) @(posedge clock);
    #1 issue(OP_HALT, '0);
    drain();

    bp_en   = 2'b10;
    bp_addr = {32'h10, 32'h40};
    push(K_HALT, "halt_and_bp", 2, 4, 1);
    issue(OP_RUN, '0);
    @(posedge clock);
    #1 issue(OP_HALT, '0);
    drain();

    bp_en = '0;
    soft_reset("soft_c");
    push(K_HOLD, "soft_in_run", RST_HOLD, 0, 0);
    push(K_HALT, "soft_in_run", 0, 0, 7);
    issue(OP_RUN, '0);
    repeat (7) @(posedge clock);
    #1 issue(OP_SOFT, '0);
    drain();

    push(K_RSTV, "rst_midstep", RESET_VEC, 0, 0);
    push(K_HOLD, "rst_midstep", RST_HOLD, 0, 0);
    push(K_HALT, "rst_midstep", 0, 0, 0);
    issue(OP_STEP, 4'd10);
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    drain();

    push(K_HALT, "saturate", 1, 15, 20);
    issue(OP_RUN, '0);
    repeat (20) @(posedge clock);
    #1 issue(OP_HALT, '0);
    drain();

    issue(OP_STEP, 4'd0);
    repeat (4) @(posedge clock);
    #1;
    push(K_HALT, "step0_then_step2", 3, 15, 2);
    issue(OP_STEP, 4'd2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "simulation time limit reached");
  end
endmodule
